// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// mux_scan_ctrl : steps a 4:1 mux through channels 0..3, samples each after
//                 DWELL cycles and presents the 4-bit word with valid/ack.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctrl #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mux_out,
   output logic       s0,
   output logic       s1,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SCAN    = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;
   localparam logic [7:0] CNT_RELOAD = 8'(DWELL - 1);

   logic [1:0] state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] cap_q, cap_d;
   logic [3:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         cnt_q   <= 8'd0;
         cap_q   <= 3'd0;
         data_q  <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = start ? ST_SCAN : ST_IDLE;
         ST_SCAN: state_d = (cnt_q == 8'd0 && sel_q == 2'd3) ? ST_DONE : ST_SCAN;
         ST_DONE: state_d = ack ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            sel_d   = 2'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (start) begin
               cnt_d  = CNT_RELOAD;
               cap_d  = 3'd0;
               busy_d = 1'b1;
            end
         end
         ST_SCAN: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               // Select advances on the same edge that samples the current channel.
               case (sel_q)
                  2'd0: cap_d[0] = mux_out;
                  2'd1: cap_d[1] = mux_out;
                  2'd2: cap_d[2] = mux_out;
                  default: begin
                     data_d  = {mux_out, cap_q};
                     valid_d = 1'b1;
                     busy_d  = 1'b0;
                  end
               endcase
               if (sel_q == 2'd3) begin
                  sel_d = 2'd0;
               end else begin
                  sel_d = sel_q + 2'd1;
                  cnt_d = CNT_RELOAD;
               end
            end
         end
         ST_DONE: begin
            sel_d  = 2'd0;
            busy_d = 1'b0;
            if (ack) valid_d = 1'b0;
         end
         default: begin
            sel_d   = 2'd0;
            cnt_d   = 8'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL 2, 1, 256) each scanning a
// behavioural 4:1 mux; expected words travel through a scoreboard queue.
`default_nettype none

module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start, ack, mux_out, s0, s1, valid, busy;
   logic [3:0] data [3];
   logic [3:0] pat  [3];
   logic [3:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int DW = (g == 0) ? 2 : (g == 1) ? 1 : 256;
         assign mux_out[g] = pat[g][{s1[g], s0[g]}];
         mux_scan_ctrl #(.DWELL(DW)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start[g]),
            .mux_out (mux_out[g]),
            .s0      (s0[g]),
            .s1      (s1[g]),
            .data    (data[g]),
            .valid   (valid[g]),
            .ack     (ack[g]),
            .busy    (busy[g])
         );
      end
   endgenerate

   function automatic int dw_of(input int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 256;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 3'b111; ack = 3'b000;
      tick(); tick();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({s1[d], s0[d], data[d], valid[d], busy[d]} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state dut%0d got sel=%b data=%h valid=%b busy=%b want all zero",
                     d, {s1[d], s0[d]}, data[d], valid[d], busy[d]);
         end
      end
      rst = 1'b0; start = 3'b000;
      tick();
      checks++;
      if (valid !== 3'b000 || busy !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got valid=%b busy=%b want 000/000", valid, busy);
      end
   endtask

   // Drives one scan from IDLE and checks select sequence, latency and word.
   task automatic run_scan(input int d, input logic [3:0] p);
      int         dw;
      int         bad;
      logic [3:0] bad_v;
      logic [3:0] exp_w;
      dw  = dw_of(d);
      bad = -1;
      bad_v = 4'h0;
      pat[d] = p;
      exp_q.push_back(p);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      for (int c = 0; c < 4 * dw; c++) begin
         if (bad < 0 && ({s1[d], s0[d]} !== 2'(c / dw) || busy[d] !== 1'b1 || valid[d] !== 1'b0)) begin
            bad   = c;
            bad_v = {s1[d], s0[d], busy[d], valid[d]};
         end
         tick();
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL scan_seq dut%0d cycle %0d got sel/busy/valid=%b want sel=%0d busy=1 valid=0",
                  d, bad, bad_v, bad / dw);
      end
      checks++;
      if (valid[d] !== 1'b1) begin
         errors++;
         $display("FAIL scan_latency dut%0d got valid=%b want 1 after %0d edges", d, valid[d], 4 * dw);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty dut%0d got data=%h want queued word", d, data[d]);
      end else begin
         exp_w = exp_q.pop_front();
         if (data[d] !== exp_w) begin
            errors++;
            $display("FAIL scan_data dut%0d got %b want %b", d, data[d], exp_w);
         end
      end
      checks++;
      if (busy[d] !== 1'b0 || {s1[d], s0[d]} !== 2'b00) begin
         errors++;
         $display("FAIL done_state dut%0d got busy=%b sel=%b want 0/00", d, busy[d], {s1[d], s0[d]});
      end
   endtask

   task automatic do_ack(input int d, input logic [3:0] w);
      ack[d] = 1'b1;
      tick();
      ack[d] = 1'b0;
      checks++;
      if (valid[d] !== 1'b0 || data[d] !== w) begin
         errors++;
         $display("FAIL ack_clear dut%0d got valid=%b data=%b want 0/%b", d, valid[d], data[d], w);
      end
   endtask

   task automatic test_basic_scan();
      run_scan(0, 4'b1101);
   endtask

   task automatic test_handshake_hold();
      int bad;
      bad = -1;
      for (int i = 0; i < 20; i++) begin
         start[0] = (i % 3 == 0);
         tick();
         if (bad < 0 && (valid[0] !== 1'b1 || data[0] !== 4'b1101 || busy[0] !== 1'b0)) bad = i;
      end
      start[0] = 1'b0;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL hold_stable cycle %0d got valid=%b data=%b busy=%b want 1/1101/0",
                  bad, valid[0], data[0], busy[0]);
      end
      do_ack(0, 4'b1101);
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      checks++;
      if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || data[0] !== 4'b1101) begin
         errors++;
         $display("FAIL ack_idle got valid=%b busy=%b data=%b want 0/0/1101", valid[0], busy[0], data[0]);
      end
   endtask

   task automatic test_reset_midscan();
      pat[0]   = 4'b1111;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({s1[0], s0[0], data[0], valid[0], busy[0]} !== 8'h00) begin
         errors++;
         $display("FAIL reset_midscan got sel=%b data=%b valid=%b busy=%b want all zero",
                  {s1[0], s0[0]}, data[0], valid[0], busy[0]);
      end
      run_scan(0, 4'b0011);
   endtask

   task automatic test_start_ack_done();
      start[0] = 1'b1;
      ack[0]   = 1'b1;
      tick();
      ack[0]   = 1'b0;
      checks++;
      if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL start_ack_done got valid=%b busy=%b want 0/0", valid[0], busy[0]);
      end
      run_scan(0, 4'b1000);
      do_ack(0, 4'b1000);
   endtask

   task automatic test_dwell1();
      run_scan(1, 4'b0110);
      do_ack(1, 4'b0110);
   endtask

   task automatic test_dwell256();
      run_scan(2, 4'b1010);
      do_ack(2, 4'b1010);
   endtask

   task automatic test_back_to_back();
      int         seen [$];
      logic [3:0] exp_w;
      pat[1] = 4'b1011;
      exp_q.push_back(4'b1011);
      exp_q.push_back(4'b1011);
      start[1] = 1'b1;
      ack[1]   = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (valid[1] === 1'b1) begin
            seen.push_back(i);
            checks++;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
            if (data[1] !== exp_w) begin
               errors++;
               $display("FAIL b2b_data edge %0d got %b want %b", i, data[1], exp_w);
            end
         end
      end
      start[1] = 1'b0;
      ack[1]   = 1'b0;
      checks++;
      if (seen.size() != 2 || seen[0] != 4 || seen[1] != 10) begin
         errors++;
         $display("FAIL b2b_timing got %0d valid cycles (first %0d) want 2 at edges 4 and 10",
                  seen.size(), (seen.size() != 0) ? seen[0] : -1);
      end
      tick();
      checks++;
      if (valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got valid=%b busy=%b want 0/0", valid[1], busy[1]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout reached got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pat[0] = 4'h0; pat[1] = 4'h0; pat[2] = 4'h0;
      test_reset();
      test_basic_scan();
      test_handshake_hold();
      test_reset_midscan();
      test_start_ack_done();
      test_dwell1();
      test_dwell256();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
